// File: rtl/can_crc_field_ctrl.sv
// CAN FD CRC field sequencer: steers the CRC destuff stage across the CRC sequence
// and reports whether the received CRC matches the locally computed one.
module can_crc_field_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_i,
    input  logic        rx_bit_i,
    input  logic        crc_start_i,
    input  logic        crc21_sel_i,
    input  logic        abort_i,
    input  logic [16:0] calc_crc_17_i,
    input  logic [20:0] calc_crc_21_i,
    input  logic [16:0] rx_crc_17_i,
    input  logic [20:0] rx_crc_21_i,
    input  logic        stuff_err_i,
    output logic        destuff_en_o,
    output logic        destuff_data_o,
    output logic        destuff_prev_o,
    output logic [8:0]  bit_cnt_o,
    output logic        busy_o,
    output logic        crc_done_o,
    output logic        crc_ok_o,
    output logic        crc_err_o,
    output logic        stuff_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t     r_state;
    logic [8:0] r_bitCnt;
    logic       r_sel21;
    logic       r_prev;
    logic       r_done;
    logic       r_ok;
    logic       r_err;
    logic       r_stuffErr;

    logic       w_en;
    logic [8:0] w_lastIdx;
    logic       w_crcEq;

    // A field may only start from IDLE on a start strobe; inside RUN every sample is forwarded.
    assign w_en = sample_i & ~abort_i &
                  (((r_state == S_IDLE) & crc_start_i) | (r_state == S_RUN));

    assign w_lastIdx = r_sel21 ? 9'd26 : 9'd21;
    assign w_crcEq   = r_sel21 ? (rx_crc_21_i == calc_crc_21_i)
                               : (rx_crc_17_i == calc_crc_17_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bitCnt   <= 9'd0;
            r_sel21    <= 1'b0;
            r_prev     <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_stuffErr <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_stuffErr <= 1'b0;
            if (sample_i) begin
                r_prev <= rx_bit_i;
            end
            if (abort_i) begin
                r_state  <= S_IDLE;
                r_bitCnt <= 9'd0;
                r_ok     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_en) begin
                            r_ok <= 1'b0;
                            if (stuff_err_i) begin
                                r_stuffErr <= 1'b1;
                            end else begin
                                r_state  <= S_RUN;
                                r_sel21  <= crc21_sel_i;
                                r_bitCnt <= 9'd1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_en) begin
                            if (stuff_err_i) begin
                                r_stuffErr <= 1'b1;
                                r_state    <= S_IDLE;
                                r_bitCnt   <= 9'd0;
                            end else if (r_bitCnt == w_lastIdx) begin
                                r_state  <= S_CHECK;
                                r_bitCnt <= 9'd0;
                            end else begin
                                r_bitCnt <= r_bitCnt + 9'd1;
                            end
                        end
                    end
                    // One settle cycle so the destuffer's CRC register holds its final value.
                    S_CHECK: begin
                        r_done  <= 1'b1;
                        r_ok    <= w_crcEq;
                        r_err   <= ~w_crcEq;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_bitCnt <= 9'd0;
                    end
                endcase
            end
        end
    end

    assign destuff_en_o   = w_en;
    assign destuff_data_o = rx_bit_i;
    assign destuff_prev_o = r_prev;
    assign bit_cnt_o      = r_bitCnt;
    assign busy_o         = (r_state != S_IDLE);
    assign crc_done_o     = r_done;
    assign crc_ok_o       = r_ok;
    assign crc_err_o      = r_err;
    assign stuff_err_o    = r_stuffErr;

endmodule

// File: doc/can_crc_field_ctrl.md
CAN_CRC_FIELD_CTRL -- requirements
Module: can_crc_field_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset (asynchronous, active-high).
REQ-002 SHALL have: sample_i  in  1  one-cycle nominal/data-phase bit sample strobe.
REQ-003 SHALL have: rx_bit_i  in  1  received bus bit, valid when sample_i=1.
REQ-004 SHALL have: crc_start_i  in  1  pulse coincident with sample_i of the first fixed stuff bit of the CRC sequence.
REQ-005 SHALL have: crc21_sel_i  in  1  1=CRC-21 frame, 0=CRC-17; sampled at crc_start_i.
REQ-006 SHALL have: abort_i  in  1  synchronous cancel (error frame/bus-off).
REQ-007 SHALL have: calc_crc_17_i  in  17, calc_crc_21_i  in  21  locally computed CRCs, stable from field start to check.
REQ-008 SHALL have: rx_crc_17_i  in  17, rx_crc_21_i  in  21, stuff_err_i  in  1  from the CRC destuff stage.
REQ-009 SHALL have: destuff_en_o  out  1, destuff_data_o  out  1, destuff_prev_o  out  1, bit_cnt_o  out  9  drive to the destuff stage.
REQ-010 SHALL have: busy_o  out  1, crc_done_o  out  1, crc_ok_o  out  1, crc_err_o  out  1, stuff_err_o  out  1.

Function
REQ-011 SHALL implement states IDLE, RUN, CHECK; state, counter and all flag outputs registered.
REQ-012 destuff_en_o SHALL be combinational: sample_i & ((IDLE & crc_start_i & ~abort_i) | (RUN & ~abort_i)).
REQ-013 destuff_data_o SHALL equal rx_bit_i combinationally.
REQ-014 destuff_prev_o SHALL be a register loaded with rx_bit_i on every sample_i in any state (prev bit before field = last stuff-count bit).
REQ-015 bit_cnt_o SHALL be 0 in IDLE; increments by 1 on each cycle destuff_en_o=1; no wrap (max 26 reached).
REQ-016 IDLE -> RUN on destuff_en_o=1; crc21_sel_i latched same edge.
REQ-017 Last bit index SHALL be 21 (CRC-17) or 26 (CRC-21); enabled sample with bit_cnt_o==last -> CHECK, bit_cnt_o cleared.
REQ-018 CHECK lasts exactly one cycle (destuffer registers now final), then -> IDLE.
REQ-019 In CHECK: compare rx_crc_X_i with calc_crc_X_i per latched select; next edge crc_done_o=1 for one cycle, crc_ok_o=equal, crc_err_o=~equal (one-cycle pulse).
REQ-020 crc_ok_o SHALL hold its value until next field start or reset; cleared to 0 on IDLE->RUN.
REQ-021 stuff_err_i=1 while destuff_en_o=1 -> next edge: stuff_err_o one-cycle pulse, state IDLE, bit_cnt_o 0, no crc_done_o for that field.
REQ-022 abort_i=1 in any state -> next edge IDLE, bit_cnt_o 0, no done/err pulses; crc_ok_o cleared.
REQ-023 Priority SHALL be abort_i > stuff error > end-of-field/advance.
REQ-024 crc_start_i in RUN or CHECK SHALL be ignored.
REQ-025 busy_o SHALL be 1 in RUN and CHECK, else 0.
REQ-026 Cycles without sample_i SHALL hold state and counter.

Reset
REQ-027 rst=1 SHALL force IDLE, bit_cnt_o=0, destuff_prev_o=0, latched select=0, crc_done_o=crc_ok_o=crc_err_o=stuff_err_o=0, immediately and asynchronously.
REQ-028 rst asserted mid-RUN SHALL discard the field; first post-reset crc_start_i begins a clean field.

Verification
REQ-029 CRC-17 field, stuff bits inverted, rx CRC = calc 0x1A5C3 -> 22 enables (bit_cnt 0..21), crc_done_o+crc_ok_o=1, crc_err_o=0.
REQ-030 CRC-21 field, rx 0x0F0F0F vs calc 0x0F0F0E -> 27 enables (0..26), crc_done_o=1, crc_err_o=1, crc_ok_o=0.
REQ-031 CRC-17 field, bit at bit_cnt 10 equal to previous bit -> stuff_err_o pulse next cycle, IDLE, no crc_done_o.
REQ-032 abort_i at bit_cnt 13 -> IDLE next cycle, bit_cnt_o=0, no pulses; following valid field passes.
REQ-033 Irregular sample_i spacing (1-7 idle cycles) plus spurious crc_start_i in RUN -> count and result identical to REQ-029.
REQ-034 rst pulse at bit_cnt 8 -> all outputs 0 while rst=1; next field checks correctly.
